// File: rtl/mux_pipe_stage_pkg.sv
// Shared definitions for the N:1 select stage: skid-buffer state encoding and widths.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int OCC_W = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_pipe_stage_if.sv
// Upstream/downstream handshake bundle of mux_pipe_stage; master drives beats in, slave is the stage.
interface mux_pipe_stage_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4
) ();

  localparam int SEL_W = sel_width(N);

  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_err, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_err, out_valid, occupancy
  );

endinterface

// File: rtl/mux_pipe_stage_mux_nx1.sv
// Combinational N:1 selector; an index with no matching input yields zero data and err=1.
module mux_nx1 #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]   i_sel,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_err
);

  always_comb begin
    o_data = '0;
    o_err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_data = i_data[i*WIDTH +: WIDTH];
        o_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Operand select stage: N:1 mux feeding a two-entry skid buffer with registered ready and flush.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input  logic           clk,
  input  logic           reset,
  mux_pipe_stage_if.slave bus
);

  localparam int SEL_W = sel_width(N);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;

  mux_nx1 #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_mux (
    .i_data (bus.in_data),
    .i_sel  (bus.in_sel),
    .o_data (w_sel_data),
    .o_err  (w_sel_err)
  );

  state_t           r_state;
  state_t           w_nxt_state;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_main_err;
  logic             r_skid_err;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic             r_in_ready;
  logic             w_accept;
  logic             w_xfer;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_xfer   = r_main_vld && bus.out_ready;

  // Main only reloads when empty or when its current beat leaves, which keeps out_data stable under stall.
  always_comb begin
    w_nxt_state      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_nxt_state = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_nxt_state    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_nxt_state = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_xfer) begin
            w_nxt_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            w_nxt_state      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_nxt_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_in_ready <= (w_nxt_state != ST_FULL);
      r_main_vld <= (w_nxt_state != ST_EMPTY);
      r_skid_vld <= (w_nxt_state == ST_FULL);
      if (w_load_main_in) begin
        r_main_data <= w_sel_data;
        r_main_err  <= w_sel_err;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_err  <= w_sel_err;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_vld;
  assign bus.out_data  = r_main_data;
  assign bus.out_err   = r_main_err;
  assign bus.occupancy = {r_skid_vld, r_main_vld & ~r_skid_vld};

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: directed scenarios on N=4 and N=3 instances plus a queue-model random run.
module tb_mux_pipe_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  mux_pipe_stage_if #(.WIDTH(64), .N(4)) if4 ();
  mux_pipe_stage_if #(.WIDTH(64), .N(3)) if3 ();

  mux_pipe_stage #(.WIDTH(64), .N(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  mux_pipe_stage #(.WIDTH(64), .N(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.in_ready, if4.occupancy, if4.out_err, if4.out_data} !== {1'b0, 1'b1, 2'd0, 1'b0, 64'd0}) begin
      n_mis++;
      $display("FAIL reset_init4: got v=%b r=%b occ=%0d e=%b d=%h want v=0 r=1 occ=0 e=0 d=0",
               if4.out_valid, if4.in_ready, if4.occupancy, if4.out_err, if4.out_data);
    end
    n_cmp++;
    if ({if3.out_valid, if3.in_ready, if3.occupancy, if3.out_data} !== {1'b0, 1'b1, 2'd0, 64'd0}) begin
      n_mis++;
      $display("FAIL reset_init3: got v=%b r=%b occ=%0d d=%h want v=0 r=1 occ=0 d=0",
               if3.out_valid, if3.in_ready, if3.occupancy, if3.out_data);
    end
    reset         = 1'b0;
    if4.in_data   = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
    if4.in_sel    = 2'd1;
    if4.in_valid  = 1'b1;
    if4.out_ready = 1'b0;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.occupancy, if4.out_data} !== {1'b1, 2'd1, 64'hA2}) begin
      n_mis++;
      $display("FAIL reset_first_accept: got v=%b occ=%0d d=%h want v=1 occ=1 d=a2",
               if4.out_valid, if4.occupancy, if4.out_data);
    end
    if4.in_sel = 2'd2;
    tick();
    n_cmp++;
    if ({if4.in_ready, if4.occupancy, if4.out_data} !== {1'b0, 2'd2, 64'hA2}) begin
      n_mis++;
      $display("FAIL reset_fill: got r=%b occ=%0d d=%h want r=0 occ=2 d=a2",
               if4.in_ready, if4.occupancy, if4.out_data);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({if4.out_valid, if4.in_ready, if4.occupancy, if4.out_data} !== {1'b0, 1'b1, 2'd0, 64'd0}) begin
      n_mis++;
      $display("FAIL reset_async_full: got v=%b r=%b occ=%0d d=%h want v=0 r=1 occ=0 d=0",
               if4.out_valid, if4.in_ready, if4.occupancy, if4.out_data);
    end
    tick();
    reset         = 1'b0;
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.occupancy} !== {1'b0, 2'd0}) begin
      n_mis++;
      $display("FAIL reset_skid_cleared: got v=%b occ=%0d want v=0 occ=0", if4.out_valid, if4.occupancy);
    end
  endtask

  task automatic test_select_sweep;
    logic [63:0] exp;
    if4.in_data   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    if4.out_ready = 1'b1;
    if4.in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if4.in_sel = 2'(s);
      exp = 64'h1111_1111_1111_1111 * 64'(s + 1);
      tick();
      n_cmp++;
      if ({if4.out_valid, if4.in_ready, if4.occupancy, if4.out_err, if4.out_data} !== {1'b1, 1'b1, 2'd1, 1'b0, exp}) begin
        n_mis++;
        $display("FAIL sweep_sel%0d: got v=%b r=%b occ=%0d e=%b d=%h want v=1 r=1 occ=1 e=0 d=%h",
                 s, if4.out_valid, if4.in_ready, if4.occupancy, if4.out_err, if4.out_data, exp);
      end
    end
    if4.in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.occupancy} !== {1'b0, 2'd0}) begin
      n_mis++;
      $display("FAIL sweep_drain: got v=%b occ=%0d want v=0 occ=0", if4.out_valid, if4.occupancy);
    end
  endtask

  task automatic test_invalid_select;
    if3.in_data   = {64'hC3C3_0000_0000_0003, 64'hB2B2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
    if3.out_ready = 1'b1;
    if3.in_valid  = 1'b1;
    if3.flush     = 1'b0;
    if3.in_sel    = 2'd3;
    tick();
    n_cmp++;
    if ({if3.out_valid, if3.out_err, if3.out_data} !== {1'b1, 1'b1, 64'd0}) begin
      n_mis++;
      $display("FAIL badsel_err: got v=%b e=%b d=%h want v=1 e=1 d=0", if3.out_valid, if3.out_err, if3.out_data);
    end
    if3.in_sel = 2'd1;
    tick();
    n_cmp++;
    if ({if3.out_valid, if3.out_err, if3.out_data} !== {1'b1, 1'b0, 64'hB2B2_0000_0000_0002}) begin
      n_mis++;
      $display("FAIL badsel_clear: got v=%b e=%b d=%h want v=1 e=0 d=b2b2000000000002",
               if3.out_valid, if3.out_err, if3.out_data);
    end
    if3.in_sel = 2'd2;
    tick();
    n_cmp++;
    if ({if3.out_err, if3.out_data} !== {1'b0, 64'hC3C3_0000_0000_0003}) begin
      n_mis++;
      $display("FAIL badsel_last: got e=%b d=%h want e=0 d=c3c3000000000003", if3.out_err, if3.out_data);
    end
    if3.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    if4.in_sel    = 2'd0;
    if4.out_ready = 1'b1;
    if4.in_valid  = 1'b1;
    if4.in_data   = {192'd0, 64'hAAAA_0000_0000_000A};
    tick();
    if4.out_ready = 1'b0;
    if4.in_data   = {192'd0, 64'hBBBB_0000_0000_000B};
    tick();
    if4.in_data = {192'd0, 64'hCCCC_0000_0000_000C};
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({if4.out_valid, if4.in_ready, if4.occupancy, if4.out_data} !== {1'b1, 1'b0, 2'd2, 64'hAAAA_0000_0000_000A}) begin
        n_mis++;
        $display("FAIL bp_hold%0d: got v=%b r=%b occ=%0d d=%h want v=1 r=0 occ=2 d=aaaa00000000000a",
                 k, if4.out_valid, if4.in_ready, if4.occupancy, if4.out_data);
      end
      tick();
    end
    if4.out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({if4.in_ready, if4.occupancy, if4.out_data} !== {1'b1, 2'd1, 64'hBBBB_0000_0000_000B}) begin
      n_mis++;
      $display("FAIL bp_release_b: got r=%b occ=%0d d=%h want r=1 occ=1 d=bbbb00000000000b",
               if4.in_ready, if4.occupancy, if4.out_data);
    end
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.occupancy, if4.out_data} !== {1'b1, 2'd1, 64'hCCCC_0000_0000_000C}) begin
      n_mis++;
      $display("FAIL bp_release_c: got v=%b occ=%0d d=%h want v=1 occ=1 d=cccc00000000000c",
               if4.out_valid, if4.occupancy, if4.out_data);
    end
    if4.in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.occupancy} !== {1'b0, 2'd0}) begin
      n_mis++;
      $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", if4.out_valid, if4.occupancy);
    end
  endtask

  task automatic test_flush;
    if4.in_sel    = 2'd3;
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.flush     = 1'b0;
    if4.in_data   = {64'hF1, 192'd0};
    tick();
    if4.in_data = {64'hF2, 192'd0};
    tick();
    if4.in_data = {64'hF3, 192'd0};
    if4.flush   = 1'b1;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.in_ready, if4.occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      n_mis++;
      $display("FAIL flush_full: got v=%b r=%b occ=%0d want v=0 r=1 occ=0",
               if4.out_valid, if4.in_ready, if4.occupancy);
    end
    if4.flush     = 1'b0;
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.occupancy} !== {1'b0, 2'd0}) begin
      n_mis++;
      $display("FAIL flush_no_ghost: got v=%b occ=%0d want v=0 occ=0", if4.out_valid, if4.occupancy);
    end
    if4.in_valid = 1'b1;
    if4.in_data  = {64'hE1, 192'd0};
    tick();
    if4.in_data = {64'hE2, 192'd0};
    if4.flush   = 1'b1;
    tick();
    n_cmp++;
    if ({if4.out_valid, if4.in_ready, if4.occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      n_mis++;
      $display("FAIL flush_accept_xfer: got v=%b r=%b occ=%0d want v=0 r=1 occ=0",
               if4.out_valid, if4.in_ready, if4.occupancy);
    end
    if4.flush    = 1'b0;
    if4.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (if4.out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL flush_accept_dropped: got v=%b want v=0", if4.out_valid);
    end
  endtask

  task automatic test_random;
    logic [64:0]  q[$];
    logic [191:0] d;
    logic [1:0]   sel;
    logic [64:0]  beat;
    logic         acc;
    logic         xfr;
    logic         fl;
    int           shown;
    shown = 0;
    for (int c = 0; c < 10000; c++) begin
      d   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sel = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 49) == 0);
      if3.in_data   = d;
      if3.in_sel    = sel;
      if3.in_valid  = ($urandom_range(0, 9) < 7);
      if3.out_ready = ($urandom_range(0, 9) < 6);
      if3.flush     = fl;
      beat = (sel < 2'd3) ? {1'b0, d[int'(sel)*64 +: 64]} : {1'b1, 64'd0};
      acc  = if3.in_valid && (q.size() < 2);
      xfr  = if3.out_ready && (q.size() > 0);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (xfr) void'(q.pop_front());
        if (acc) q.push_back(beat);
      end
      n_cmp++;
      if ({if3.out_valid, if3.in_ready, if3.occupancy} !== {q.size() > 0, q.size() < 2, 2'(q.size())}) begin
        n_mis++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand_ctrl@%0d: got v=%b r=%b occ=%0d want occ=%0d", c,
                   if3.out_valid, if3.in_ready, if3.occupancy, q.size());
        end
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({if3.out_err, if3.out_data} !== q[0]) begin
          n_mis++;
          if (shown < 20) begin
            shown++;
            $display("FAIL rand_data@%0d: got e=%b d=%h want e=%b d=%h", c,
                     if3.out_err, if3.out_data, q[0][64], q[0][63:0]);
          end
        end
      end
    end
    if3.in_valid = 1'b0;
    if3.flush    = 1'b0;
  endtask

  initial begin
    n_cmp         = 0;
    n_mis         = 0;
    reset         = 1'b1;
    if4.in_data   = '0;
    if4.in_sel    = '0;
    if4.in_valid  = 1'b0;
    if4.flush     = 1'b0;
    if4.out_ready = 1'b0;
    if3.in_data   = '0;
    if3.in_sel    = '0;
    if3.in_valid  = 1'b0;
    if3.flush     = 1'b0;
    if3.out_ready = 1'b1;
    tick();
    test_reset();
    test_select_sweep();
    test_invalid_select();
    test_backpressure();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mux_pipe_stage.md
# mux_pipe_stage

Parametrised N-input select stage with a registered, elastic output for the pipelined RISC-V datapath. Picks one of N WIDTH-bit operands per beat (operand/forwarding selection), then registers it behind a two-entry skid buffer with valid/ready handshake, pipeline flush and an out-of-range-select flag. Replaces ad-hoc 2:1 muxes feeding pipeline registers, so stalls can back-propagate without combinational ready paths.

## Interface
- WIDTH, 64, data bits per input and output
- N, 4, number of selectable inputs (N >= 2)
- SEL_W, $clog2(N), select width (derived, do not override)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  N*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
- in_sel  in  SEL_W  index of input to capture
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready
- flush  in  1  synchronous discard of all held beats
- out_data  out  WIDTH  selected, registered data
- out_err  out  1  beat was captured with in_sel >= N
- out_valid  out  1  out_data/out_err valid
- out_ready  in  1  downstream accepts
- occupancy  out  2  beats held (0, 1, 2)

## Operation
- Accept: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Select: in_sel < N -> data = input[in_sel], err = 0; in_sel >= N (only possible when N not a power of 2) -> data = 0, err = 1. err travels with the beat.
- Storage: main register (drives outputs) and skid register; each holds {data, err, valid}.
- States: EMPTY (0 beats), ONE (main only), FULL (main + skid).
  - EMPTY: accept -> ONE.
  - ONE: accept & transfer -> ONE (main replaced); accept & !transfer -> FULL (beat to skid); transfer only -> EMPTY; neither -> ONE.
  - FULL: transfer -> ONE (skid moves to main); otherwise hold. No accept possible (in_ready = 0).
- in_ready = (state != FULL), registered from next state.
- flush: next state EMPTY regardless of other inputs; a beat accepted in the flush cycle is discarded; a transfer in the flush cycle still completes downstream (out_valid was already high). flush overrides everything except reset.
- Data of the main register must not change while out_valid && !out_ready (stable-hold rule).
- reset (async, any time incl. mid-transfer): state EMPTY, out_valid 0, out_data 0, out_err 0, occupancy 0, in_ready 1, skid cleared.

## Timing
- Latency: accepted beat appears on out_valid the next cycle when stage was EMPTY or ONE-with-transfer.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure: out_ready low for k cycles -> at most one extra beat absorbed; in_ready drops the cycle after FULL is entered.
- in_ready rises the cycle after FULL -> ONE.
- All outputs are register-driven; no input-to-output combinational path.
- After reset deasserts, first accept possible on the next rising edge.

## Structure
- Shared package mux_pkg: state encoding constants (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2), occupancy width.
- Sub-module mux_nx1: combinational parametrised N:1 selector (WIDTH, N) producing data and err; instantiated once ahead of the skid buffer. Skid/FSM logic stays in mux_pipe_stage.

## Test plan
- Reset: assert reset mid-stream with state FULL -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=0.
- Select sweep, WIDTH=64, N=4: in_data inputs 0x11..,0x22..,0x33..,0x44.. ; in_sel 0..3, out_ready=1 -> out_data matches each one cycle later, out_err=0, one beat per cycle.
- Invalid select, N=3: in_sel=3 -> out_data=0, out_err=1; next beat in_sel=1 -> err clears.
- Backpressure: stream beats A,B,C with out_ready=0 from cycle after A -> A held stable, B in skid, occupancy=2, in_ready=0, C held upstream; release out_ready -> A,B,C in order, no loss/duplication.
- Flush: state FULL plus accept in same cycle as flush -> next cycle occupancy=0, out_valid=0, in_ready=1; flushed beats never appear.
- Random stress: random in_valid/out_ready/in_sel 10k cycles vs. scoreboard queue model -> ordering, data, err, occupancy all match.
